neural_soc_isig_result_fifo: RTL

- Upstream feeder for the 32-bit software-visible isig input port.
- Buffers neuron/sigmoid results from the neural core in a small show-ahead FIFO.
- Drives a stable 32-bit status+data word onto the input port's in_port.
- Software consumes entries by toggling one bit on an output port (sw_ack_tog). No read strobe is needed from the input port.

---
 rtl/neural_soc_isig_result_fifo_if.sv | 33 +++
 rtl/neural_soc_isig_result_fifo.sv | 122 ++++++++++++
 2 files changed

// File: rtl/neural_soc_isig_result_fifo_if.sv
// ---------------------------------------------------------------------------
// neural_soc_isig_result_fifo_if
// Purpose : bundles the neural-core result stream, the software pop/flush
//           controls and the registered status word of the isig result FIFO.
// Signals :
//   res_valid  - neural core result valid
//   res_data   - neural core result, signed Q8.16
//   res_ready  - FIFO can accept (not full)
//   sw_ack_tog - software pop request, every level change is one pop
//   sw_clear   - synchronous level-sensitive flush
//   out_word   - registered status+data word for the isig in_port
//   irq        - registered level interrupt, high while FIFO is non-empty
// Modports: master = producer/software side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface neural_soc_isig_result_fifo_if;
  logic               res_valid;
  logic signed [23:0] res_data;
  logic               res_ready;
  logic               sw_ack_tog;
  logic               sw_clear;
  logic [31:0]        out_word;
  logic               irq;

  modport master (
    output res_valid, res_data, sw_ack_tog, sw_clear,
    input  res_ready, out_word, irq
  );

  modport slave (
    input  res_valid, res_data, sw_ack_tog, sw_clear,
    output res_ready, out_word, irq
  );
endinterface

// File: rtl/neural_soc_isig_result_fifo.sv
// ---------------------------------------------------------------------------
// neural_soc_isig_result_fifo
// Purpose : show-ahead FIFO between the neural core and the software-visible
//           isig input port. Presents a stable registered word
//           {head_valid, overflow, 0, count[4:0], head_data[23:0]}; software
//           pops an entry by toggling sw_ack_tog.
// Ports   :
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - slave modport of neural_soc_isig_result_fifo_if
// Parameters: DEPTH (power of two, 2..16), AW = log2(DEPTH).
// ---------------------------------------------------------------------------
module neural_soc_isig_result_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  neural_soc_isig_result_fifo_if.slave bus
);

  localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

  // Storage carries no reset; its contents are don't-care until written.
  logic signed [23:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_ack_q;
  logic [31:0]   r_out_word;
  logic          r_irq;

  logic               w_full;
  logic               w_empty;
  logic               w_ack_edge;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [AW-1:0]      w_wr_ptr_next;
  logic [AW-1:0]      w_rd_ptr_next;
  logic [AW:0]        w_count_next;
  logic               w_ovf_next;
  logic [4:0]         w_count5;
  logic signed [23:0] w_head;
  logic [31:0]        w_out_next;

  // Next-state computation from the current registered state
  always_comb begin
    w_full        = (r_count == L_FULL_CNT);
    w_empty       = (r_count == '0);
    w_ack_edge    = bus.sw_ack_tog ^ r_ack_q;
    // Fullness is judged before any same-cycle pop, so a full FIFO drops.
    w_push        = bus.res_valid & ~w_full;
    w_drop        = bus.res_valid & w_full;
    // A toggle on an empty FIFO is silently ignored, even with a push.
    w_pop         = w_ack_edge & ~w_empty;

    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    w_ovf_next    = r_ovf;

    if (bus.sw_clear) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_count_next  = '0;
      w_ovf_next    = 1'b0;
    end else begin
      if (w_push) w_wr_ptr_next = r_wr_ptr + AW'(1);
      if (w_pop)  w_rd_ptr_next = r_rd_ptr + AW'(1);
      w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      w_ovf_next   = r_ovf | w_drop;
    end

    // The new head is the entry being written this cycle when the read
    // pointer lands on the write slot while pushing (empty FIFO, or a single
    // entry popped alongside a push); the memory is not updated yet, so the
    // incoming data is forwarded.
    w_head = '0;
    if (!bus.sw_clear && (w_count_next != '0)) begin
      if (w_push && (w_rd_ptr_next == r_wr_ptr)) w_head = bus.res_data;
      else                                       w_head = r_mem[w_rd_ptr_next];
    end

    w_count5   = 5'(w_count_next);
    w_out_next = {(w_count_next != '0), w_ovf_next, 1'b0, w_count5, w_head};
  end

  assign bus.res_ready = ~w_full;
  assign bus.out_word  = r_out_word;
  assign bus.irq       = r_irq;

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_ack_q    <= 1'b0;
      r_out_word <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_count    <= w_count_next;
      r_ovf      <= w_ovf_next;
      // Tracks the toggle even during a flush so no stale edge survives it.
      r_ack_q    <= bus.sw_ack_tog;
      r_out_word <= w_out_next;
      r_irq      <= (w_count_next != '0);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_push && !bus.sw_clear) r_mem[r_wr_ptr] <= bus.res_data;
  end

endmodule
